// File: rtl/ram_arb_pkg.sv
// Shared constants and types for ram_port_arbiter.
// The request payload is packed {ctrl, data, addr} with ctrl at the MSB.
// The struct is typedef'd inside the arbiter because its widths are parameters.
package ram_arb_pkg;

    localparam logic CTRL_WR = 1'b1;
    localparam logic CTRL_RD = 1'b0;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_t;

    // Index of the requester that is not idx (two requesters only).
    function automatic logic other_idx(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Valid/ready (DTI) channel: producer drives valid/data, consumer drives ready.
interface dti #(
    parameter int unsigned W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/ram_arb_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding read.
// DEPTH must be a power of two so the pointers wrap naturally.
module ram_arb_tag_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       din,
    output logic                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned W_PTR = $clog2(DEPTH);
    localparam int unsigned W_CNT = W_PTR + 1;

    logic [DEPTH-1:0] mem;
    logic [W_PTR-1:0] wr_ptr;
    logic [W_PTR-1:0] rd_ptr;
    logic [W_CNT-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt == W_CNT'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy tracking; push+pop together leaves cnt unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= W_PTR'(wr_ptr + W_PTR'(1));
            if (do_pop)  rd_ptr <= W_PTR'(rd_ptr + W_PTR'(1));
            case ({do_push, do_pop})
                2'b10:   cnt <= W_CNT'(cnt + W_CNT'(1));
                2'b01:   cnt <= W_CNT'(cnt - W_CNT'(1));
                default: cnt <= cnt;
            endcase
        end
    end

    // Tag storage; contents are meaningless outside [rd_ptr, wr_ptr).
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one memory request/response port between two DTI requesters.
// Requests are muxed combinationally onto mem_req; a tag FIFO routes
// in-order read data back to the requester that issued each read.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (req0 wins);
// otherwise arbitration is round-robin.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned W_DATA    = 16,
    parameter int unsigned W_ADDR    = 16,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic   clk,
    input  logic   rst,
    dti.consumer   req0,
    dti.consumer   req1,
    dti.producer   dout0,
    dti.producer   dout1,
    dti.producer   mem_req,
    dti.consumer   mem_dout
);
    localparam int unsigned W_CNT = $clog2(MAX_OUTST) + 1;

    typedef struct packed {
        logic              ctrl;
        logic [W_DATA-1:0] data;
        logic [W_ADDR-1:0] addr;
    } req_t;

    req_t             r0;
    req_t             r1;
    req_t             sel_req;
    logic [W_CNT-1:0] tag_cnt;
    logic             tag_full;
    logic             tag_empty;
    logic             tag_head;
    logic             tag_push;
    logic             tag_pop;
    logic             elig0;
    logic             elig1;
    logic             grant;
    logic             grant_vld;
    logic             req_hs;
    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             hold_idx;
    logic             hold_idx_nxt;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic             rr_last;
    logic             rr_last_nxt;
`endif

    assign r0 = req_t'(req0.data);
    assign r1 = req_t'(req1.data);

    // Reads are blocked on the registered count, so a same-cycle pop never unblocks one.
    assign elig0 = req0.valid && ((r0.ctrl == CTRL_WR) || !tag_full);
    assign elig1 = req1.valid && ((r1.ctrl == CTRL_WR) || !tag_full);

    // Grant state, hold index and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            hold_idx <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_last  <= 1'b1;
`endif
        end else begin
            state    <= state_nxt;
            hold_idx <= hold_idx_nxt;
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_last  <= rr_last_nxt;
`endif
        end
    end

    // Grant selection, request mux, requester readies and next state.
    always_comb begin
        state_nxt     = state;
        hold_idx_nxt  = hold_idx;
        grant         = 1'b0;
        grant_vld     = 1'b0;
        req_hs        = 1'b0;
        tag_push      = 1'b0;
        sel_req       = r0;
        mem_req.valid = 1'b0;
        mem_req.data  = '0;
        req0.ready    = 1'b0;
        req1.ready    = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        rr_last_nxt   = rr_last;
`endif

        case (state)
            ARB_IDLE: begin
                if (elig0 && elig1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                    grant = 1'b0;
`else
                    grant = other_idx(rr_last);
`endif
                    grant_vld = 1'b1;
                end else if (elig0) begin
                    grant     = 1'b0;
                    grant_vld = 1'b1;
                end else if (elig1) begin
                    grant     = 1'b1;
                    grant_vld = 1'b1;
                end
            end
            ARB_HOLD: begin
                // Frozen grant keeps mem_req valid/data stable until accepted.
                grant     = hold_idx;
                grant_vld = hold_idx ? req1.valid : req0.valid;
            end
            default: begin
                grant     = 1'b0;
                grant_vld = 1'b0;
            end
        endcase

        sel_req = grant ? r1 : r0;

        if (grant_vld && !rst) begin
            mem_req.valid = 1'b1;
            mem_req.data  = sel_req;
            req_hs        = mem_req.ready;
            if (grant) req1.ready = mem_req.ready;
            else       req0.ready = mem_req.ready;
        end

        tag_push = req_hs && (sel_req.ctrl == CTRL_RD);

        if (state == ARB_IDLE && grant_vld && !rst && !mem_req.ready) begin
            state_nxt    = ARB_HOLD;
            hold_idx_nxt = grant;
        end else if (state == ARB_HOLD && req_hs) begin
            state_nxt = ARB_IDLE;
        end

`ifndef RAM_ARB_FIXED_PRIO_EN
        if (req_hs) rr_last_nxt = grant;
`endif
    end

    // Response routing by tag FIFO head; responses with no owner are sunk.
    always_comb begin
        dout0.valid    = 1'b0;
        dout1.valid    = 1'b0;
        dout0.data     = mem_dout.data;
        dout1.data     = mem_dout.data;
        mem_dout.ready = 1'b0;
        tag_pop        = 1'b0;
        if (!rst) begin
            if (tag_empty) begin
                mem_dout.ready = 1'b1;
            end else if (tag_head) begin
                dout1.valid    = mem_dout.valid;
                mem_dout.ready = dout1.ready;
            end else begin
                dout0.valid    = mem_dout.valid;
                mem_dout.ready = dout0.ready;
            end
            tag_pop = mem_dout.valid && mem_dout.ready && !tag_empty;
        end
    end

    ram_arb_tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (grant),
        .head  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_cnt)
    );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (round-robin build).
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned W_DATA = 16;
    localparam int unsigned W_ADDR = 16;
    localparam int unsigned W_REQ  = 1 + W_DATA + W_ADDR;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    dti #(.W(W_REQ))  req0_if ();
    dti #(.W(W_REQ))  req1_if ();
    dti #(.W(W_REQ))  mem_req_if ();
    dti #(.W(W_DATA)) dout0_if ();
    dti #(.W(W_DATA)) dout1_if ();
    dti #(.W(W_DATA)) mem_dout_if ();

    ram_port_arbiter #(
        .W_DATA    (W_DATA),
        .W_ADDR    (W_ADDR),
        .MAX_OUTST (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0_if),
        .req1     (req1_if),
        .dout0    (dout0_if),
        .dout1    (dout1_if),
        .mem_req  (mem_req_if),
        .mem_dout (mem_dout_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W_REQ-1:0] rd(input logic [15:0] a);
        return {CTRL_RD, 16'h0000, a};
    endfunction

    function automatic logic [W_REQ-1:0] wr(input logic [15:0] d, input logic [15:0] a);
        return {CTRL_WR, d, a};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_if.valid     = 1'b0;
        req0_if.data      = '0;
        req1_if.valid     = 1'b0;
        req1_if.data      = '0;
        mem_req_if.ready  = 1'b1;
        mem_dout_if.valid = 1'b0;
        mem_dout_if.data  = '0;
        dout0_if.ready    = 1'b1;
        dout1_if.ready    = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        req0_if.valid = 1'b1;
        req0_if.data  = rd(16'h0001);
        mem_dout_if.valid = 1'b1;
        mem_dout_if.data  = 16'h1111;
        step();
        #2;
        n_cmp++; if (mem_req_if.valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req_valid got %b want 0", mem_req_if.valid); end
        n_cmp++; if (req0_if.ready !== 1'b0) begin n_bad++; $display("FAIL reset_req0_ready got %b want 0", req0_if.ready); end
        n_cmp++; if (mem_dout_if.ready !== 1'b0) begin n_bad++; $display("FAIL reset_mem_dout_ready got %b want 0", mem_dout_if.ready); end
        n_cmp++; if ({dout0_if.valid, dout1_if.valid} !== 2'b00) begin n_bad++; $display("FAIL reset_dout_valid got %b want 00", {dout0_if.valid, dout1_if.valid}); end
        step();
        rst = 1'b0;
        idle_inputs();
        #2;
        n_cmp++; if (dut.tag_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_tag_cnt got %0d want 0", dut.tag_cnt); end
        step();
    endtask

    // Both requesters stream reads: grants must alternate 0,1,0,1.
    task automatic test_contention();
        logic [15:0] rdata [4];
        rdata[0] = 16'h00A0; rdata[1] = 16'h00A1; rdata[2] = 16'h00A2; rdata[3] = 16'h00A3;
        req0_if.valid = 1'b1; req0_if.data = rd(16'h0010);
        req1_if.valid = 1'b1; req1_if.data = rd(16'h0011);
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++; if ({req1_if.ready, req0_if.ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL cont_grant[%0d] got r1r0=%b want %b", i, {req1_if.ready, req0_if.ready}, ((i % 2 == 0) ? 2'b01 : 2'b10)); end
            n_cmp++; if (mem_req_if.data !== ((i % 2 == 0) ? rd(16'h0010) : rd(16'h0011))) begin n_bad++; $display("FAIL cont_mem_req_data[%0d] got %h", i, mem_req_if.data); end
            step();
        end
        req0_if.valid = 1'b0;
        req1_if.valid = 1'b0;
        #2;
        n_cmp++; if (dut.tag_cnt !== 3'd4) begin n_bad++; $display("FAIL cont_tag_cnt got %0d want 4", dut.tag_cnt); end
        for (int i = 0; i < 4; i++) begin
            mem_dout_if.valid = 1'b1;
            mem_dout_if.data  = rdata[i];
            #2;
            n_cmp++; if ({dout1_if.valid, dout0_if.valid} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL cont_resp_route[%0d] got v1v0=%b want %b", i, {dout1_if.valid, dout0_if.valid}, ((i % 2 == 0) ? 2'b01 : 2'b10)); end
            n_cmp++; if (((i % 2 == 0) ? dout0_if.data : dout1_if.data) !== rdata[i]) begin n_bad++; $display("FAIL cont_resp_data[%0d] got %h want %h", i, ((i % 2 == 0) ? dout0_if.data : dout1_if.data), rdata[i]); end
            step();
        end
        mem_dout_if.valid = 1'b0;
        #2;
        n_cmp++; if (dut.tag_cnt !== 3'd0) begin n_bad++; $display("FAIL cont_tag_cnt_drained got %0d want 0", dut.tag_cnt); end
        step();
    endtask

    // req1 stalls in HOLD; req0 appearing meanwhile must not steal the port.
    task automatic test_hold();
        mem_req_if.ready = 1'b0;
        req1_if.valid = 1'b1; req1_if.data = wr(16'h1234, 16'h0022);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin req0_if.valid = 1'b1; req0_if.data = rd(16'h0033); end
            #2;
            n_cmp++; if (mem_req_if.data !== wr(16'h1234, 16'h0022)) begin n_bad++; $display("FAIL hold_data[%0d] got %h want %h", i, mem_req_if.data, wr(16'h1234, 16'h0022)); end
            n_cmp++; if ({mem_req_if.valid, req1_if.ready, req0_if.ready} !== 3'b100) begin n_bad++; $display("FAIL hold_ctl[%0d] got v/r1/r0=%b want 100", i, {mem_req_if.valid, req1_if.ready, req0_if.ready}); end
            step();
        end
        mem_req_if.ready = 1'b1;
        #2;
        n_cmp++; if ({req1_if.ready, req0_if.ready} !== 2'b10 || mem_req_if.data !== wr(16'h1234, 16'h0022)) begin n_bad++; $display("FAIL hold_release got r1r0=%b data=%h want 10", {req1_if.ready, req0_if.ready}, mem_req_if.data); end
        step();
        #2;
        n_cmp++; if ({req1_if.ready, req0_if.ready} !== 2'b01 || mem_req_if.data !== rd(16'h0033)) begin n_bad++; $display("FAIL hold_next_grant got r1r0=%b data=%h want 01", {req1_if.ready, req0_if.ready}, mem_req_if.data); end
        step();
        req0_if.valid = 1'b0;
        req1_if.valid = 1'b0;
        mem_dout_if.valid = 1'b1;
        mem_dout_if.data  = 16'h5555;
        #2;
        n_cmp++; if ({dout1_if.valid, dout0_if.valid} !== 2'b01 || dout0_if.data !== 16'h5555) begin n_bad++; $display("FAIL hold_resp got v1v0=%b data=%h want 01/5555", {dout1_if.valid, dout0_if.valid}, dout0_if.data); end
        step();
        mem_dout_if.valid = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        req0_if.valid = 1'b1; req0_if.data = rd(16'h0005);
        #2;
        n_cmp++; if (mem_req_if.valid !== 1'b1 || mem_req_if.data !== rd(16'h0005)) begin n_bad++; $display("FAIL single_mem_req got v=%b d=%h want 1/%h", mem_req_if.valid, mem_req_if.data, rd(16'h0005)); end
        n_cmp++; if ({req1_if.ready, req0_if.ready} !== 2'b01) begin n_bad++; $display("FAIL single_ready got r1r0=%b want 01", {req1_if.ready, req0_if.ready}); end
        step();
        req0_if.valid = 1'b0;
        #2;
        n_cmp++; if (dut.tag_cnt !== 3'd1) begin n_bad++; $display("FAIL single_tag_cnt got %0d want 1", dut.tag_cnt); end
        step();
        mem_dout_if.valid = 1'b1; mem_dout_if.data = 16'hBEEF;
        #2;
        n_cmp++; if (dout0_if.valid !== 1'b1 || dout0_if.data !== 16'hBEEF) begin n_bad++; $display("FAIL single_dout0 got v=%b d=%h want 1/beef", dout0_if.valid, dout0_if.data); end
        n_cmp++; if (dout1_if.valid !== 1'b0 || mem_dout_if.ready !== 1'b1) begin n_bad++; $display("FAIL single_dout1_or_ready got v1=%b rdy=%b want 0/1", dout1_if.valid, mem_dout_if.ready); end
        step();
        mem_dout_if.valid = 1'b0;
        #2;
        n_cmp++; if (dut.tag_cnt !== 3'd0) begin n_bad++; $display("FAIL single_tag_cnt_end got %0d want 0", dut.tag_cnt); end
        step();
    endtask

    // Fill the tag FIFO; a 5th read waits, a write still passes.
    task automatic test_full_fifo();
        for (int i = 0; i < 4; i++) begin
            req0_if.valid = 1'b1; req0_if.data = rd(16'(16'h0040 + i));
            #2;
            n_cmp++; if (req0_if.ready !== 1'b1) begin n_bad++; $display("FAIL full_fill_ready[%0d] got %b want 1", i, req0_if.ready); end
            step();
        end
        req0_if.data = rd(16'h0044);
        req1_if.valid = 1'b1; req1_if.data = wr(16'hCAFE, 16'h0050);
        #2;
        n_cmp++; if ({req1_if.ready, req0_if.ready} !== 2'b10 || mem_req_if.data !== wr(16'hCAFE, 16'h0050)) begin n_bad++; $display("FAIL full_write_passes got r1r0=%b d=%h want 10", {req1_if.ready, req0_if.ready}, mem_req_if.data); end
        step();
        req1_if.valid = 1'b0;
        #2;
        n_cmp++; if (req0_if.ready !== 1'b0 || mem_req_if.valid !== 1'b0) begin n_bad++; $display("FAIL full_read_blocked got r0=%b v=%b want 0/0", req0_if.ready, mem_req_if.valid); end
        step();
        mem_dout_if.valid = 1'b1; mem_dout_if.data = 16'h00D0;
        #2;
        n_cmp++; if (req0_if.ready !== 1'b0 || dout0_if.valid !== 1'b1) begin n_bad++; $display("FAIL full_same_cycle_pop got r0=%b dv0=%b want 0/1", req0_if.ready, dout0_if.valid); end
        step();
        mem_dout_if.valid = 1'b0;
        #2;
        n_cmp++; if (req0_if.ready !== 1'b1 || mem_req_if.data !== rd(16'h0044)) begin n_bad++; $display("FAIL full_5th_accepted got r0=%b d=%h want 1", req0_if.ready, mem_req_if.data); end
        step();
        req0_if.valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            mem_dout_if.valid = 1'b1; mem_dout_if.data = 16'(16'h00D0 + i);
            #2;
            n_cmp++; if ({dout1_if.valid, dout0_if.valid} !== 2'b01 || dout0_if.data !== 16'(16'h00D0 + i)) begin n_bad++; $display("FAIL full_drain[%0d] got v1v0=%b d=%h", i, {dout1_if.valid, dout0_if.valid}, dout0_if.data); end
            step();
        end
        mem_dout_if.valid = 1'b0;
        #2;
        n_cmp++; if (dut.tag_cnt !== 3'd0) begin n_bad++; $display("FAIL full_tag_cnt_end got %0d want 0", dut.tag_cnt); end
        step();
    endtask

    // Stalled dout0 must stall mem_dout; also sink an ownerless response.
    task automatic test_backpressure();
        req0_if.valid = 1'b1; req0_if.data = rd(16'h0060);
        step();
        req0_if.valid = 1'b0;
        mem_dout_if.valid = 1'b1; mem_dout_if.data = 16'h7777;
        dout0_if.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_cmp++; if (mem_dout_if.ready !== 1'b0 || dout0_if.valid !== 1'b1) begin n_bad++; $display("FAIL bp_stall[%0d] got rdy=%b dv0=%b want 0/1", i, mem_dout_if.ready, dout0_if.valid); end
            step();
        end
        n_cmp++; if (dut.tag_cnt !== 3'd1) begin n_bad++; $display("FAIL bp_tag_cnt got %0d want 1", dut.tag_cnt); end
        dout0_if.ready = 1'b1;
        #2;
        n_cmp++; if (mem_dout_if.ready !== 1'b1 || dout0_if.data !== 16'h7777) begin n_bad++; $display("FAIL bp_release got rdy=%b d=%h want 1/7777", mem_dout_if.ready, dout0_if.data); end
        step();
        mem_dout_if.data = 16'h9999;
        #2;
        n_cmp++; if ({mem_dout_if.ready, dout1_if.valid, dout0_if.valid} !== 3'b100) begin n_bad++; $display("FAIL orphan_resp got rdy/v1/v0=%b want 100", {mem_dout_if.ready, dout1_if.valid, dout0_if.valid}); end
        step();
        mem_dout_if.valid = 1'b0;
        step();
    endtask

    // Reset with reads in flight; afterwards req0 wins the first tie again.
    task automatic test_reset_mid();
        req0_if.valid = 1'b1; req0_if.data = rd(16'h0070);
        step();
        req0_if.data = rd(16'h0071);
        step();
        req0_if.valid = 1'b0;
        #2;
        n_cmp++; if (dut.tag_cnt !== 3'd2) begin n_bad++; $display("FAIL rstmid_pre_cnt got %0d want 2", dut.tag_cnt); end
        rst = 1'b1;
        req0_if.valid = 1'b1; req0_if.data = rd(16'h0072);
        req1_if.valid = 1'b1; req1_if.data = rd(16'h0073);
        mem_dout_if.valid = 1'b1; mem_dout_if.data = 16'h4242;
        #2;
        n_cmp++; if ({mem_req_if.valid, req0_if.ready, req1_if.ready, mem_dout_if.ready, dout0_if.valid, dout1_if.valid} !== 6'b0) begin n_bad++; $display("FAIL rstmid_outputs got %b want 000000", {mem_req_if.valid, req0_if.ready, req1_if.ready, mem_dout_if.ready, dout0_if.valid, dout1_if.valid}); end
        step();
        rst = 1'b0;
        mem_dout_if.valid = 1'b0;
        #2;
        n_cmp++; if (dut.tag_cnt !== 3'd0) begin n_bad++; $display("FAIL rstmid_cnt got %0d want 0", dut.tag_cnt); end
        n_cmp++; if ({req1_if.ready, req0_if.ready} !== 2'b01 || mem_req_if.data !== rd(16'h0072)) begin n_bad++; $display("FAIL rstmid_tie got r1r0=%b d=%h want 01", {req1_if.ready, req0_if.ready}, mem_req_if.data); end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_contention();
        test_hold();
        test_single_read();
        test_full_fifo();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end

endmodule
